ysyx_041461_mul_seq: RTL and testbench

YSYX_041461_MUL_SEQ -- requirements
Module: ysyx_041461_mul_seq

---
 rtl/ysyx_041461_mul_seq.sv | 148 ++++++++++++++
 tb/tb_ysyx_041461_mul_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_041461_mul_seq.sv
// Sequential shift-add multiplier with a sign-magnitude front end.
// Operands are converted to magnitudes at accept, multiplied BPC bits per
// cycle, then the product is conditionally negated in a single fix-up cycle.
// Word mode multiplies only the low halves and sign-extends the low half of
// the product.
module ysyx_041461_mul_seq #(
    parameter int XLEN = 64,
    parameter int BPC  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            MUL_valid_in,
    input  logic            MUL_flush,
    input  logic            MUL_mulw,
    input  logic [1:0]      MUL_signed,
    input  logic [XLEN-1:0] MUL_multiplicand,
    input  logic [XLEN-1:0] MUL_multiplier,
    output logic            MUL_ready,
    output logic            MUL_valid_out,
    output logic [XLEN-1:0] MUL_result_hi,
    output logic [XLEN-1:0] MUL_result_lo
);

    localparam int HALF = XLEN / 2;
    localparam int CW   = $clog2(XLEN / BPC + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Counter reload values: the counter runs down to zero, so load N-1
    localparam logic [CW-1:0] FULL_LAST = CW'(XLEN / BPC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(XLEN / (2 * BPC) - 1);

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] acc;
    logic              neg;
    logic              mulw_r;

    logic [XLEN-1:0]   a_ext;
    logic [XLEN-1:0]   b_ext;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;

    assign MUL_ready = (state == IDLE);

    // Operand conditioning: word mode folds the half-width sign into the
    // full-width operand, so one magnitude path serves both modes. The
    // magnitude of the most negative value still fits as an unsigned XLEN.
    always_comb begin
        a_ext = MUL_multiplicand;
        b_ext = MUL_multiplier;
        if (MUL_mulw) begin
            a_ext = {{HALF{MUL_signed[1] & MUL_multiplicand[HALF-1]}}, MUL_multiplicand[HALF-1:0]};
            b_ext = {{HALF{MUL_signed[0] & MUL_multiplier[HALF-1]}}, MUL_multiplier[HALF-1:0]};
        end
        a_neg = MUL_signed[1] & a_ext[XLEN-1];
        b_neg = MUL_signed[0] & b_ext[XLEN-1];
        a_mag = a_neg ? (~a_ext + 1'b1) : a_ext;
        b_mag = b_neg ? (~b_ext + 1'b1) : b_ext;
    end

    // One CALC step: add the shifted multiplicand for each of the BPC
    // multiplier bits currently at the bottom of the multiplier register
    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BPC; i++) begin
            if (mplier[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
    end

    // Fix-up: restore the sign of the product from its magnitude
    always_comb begin
        prod = neg ? (~acc + 1'b1) : acc;
    end

    // Control FSM plus datapath registers; flush in CALC/FIX abandons the
    // operation without touching the result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            count         <= '0;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            neg           <= 1'b0;
            mulw_r        <= 1'b0;
            MUL_valid_out <= 1'b0;
            MUL_result_hi <= '0;
            MUL_result_lo <= '0;
        end else begin
            MUL_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (MUL_valid_in && !MUL_flush) begin
                        mcand  <= {{XLEN{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        neg    <= a_neg ^ b_neg;
                        mulw_r <= MUL_mulw;
                        count  <= MUL_mulw ? HALF_LAST : FULL_LAST;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (MUL_flush) begin
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << BPC;
                        mplier <= mplier >> BPC;
                        if (count == '0) begin
                            state <= FIX;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!MUL_flush) begin
                        MUL_valid_out <= 1'b1;
                        if (mulw_r) begin
                            MUL_result_hi <= '0;
                            MUL_result_lo <= {{HALF{prod[HALF-1]}}, prod[HALF-1:0]};
                        end else begin
                            MUL_result_hi <= prod[2*XLEN-1:XLEN];
                            MUL_result_lo <= prod[XLEN-1:0];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_041461_mul_seq.sv
// Scoreboard bench for ysyx_041461_mul_seq: stimulus pushes expected results
// and accept times, a monitor pops and checks them on every valid_out strobe.
module tb_ysyx_041461_mul_seq;

    logic        clk;
    logic        rst;
    logic        MUL_valid_in;
    logic        MUL_flush;
    logic        MUL_mulw;
    logic [1:0]  MUL_signed;
    logic [63:0] MUL_multiplicand;
    logic [63:0] MUL_multiplier;
    logic        MUL_ready;
    logic        MUL_valid_out;
    logic [63:0] MUL_result_hi;
    logic [63:0] MUL_result_lo;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int          acc_cyc;
        int          lat;
        int          id;
    } exp_t;

    exp_t        sb[$];
    int          checks;
    int          errors;
    int          cyc;
    logic [63:0] last_hi;
    logic [63:0] last_lo;
    int          ready_hi;

    ysyx_041461_mul_seq #(.XLEN(64), .BPC(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .MUL_valid_in     (MUL_valid_in),
        .MUL_flush        (MUL_flush),
        .MUL_mulw         (MUL_mulw),
        .MUL_signed       (MUL_signed),
        .MUL_multiplicand (MUL_multiplicand),
        .MUL_multiplier   (MUL_multiplier),
        .MUL_ready        (MUL_ready),
        .MUL_valid_out    (MUL_valid_out),
        .MUL_result_hi    (MUL_result_hi),
        .MUL_result_lo    (MUL_result_lo)
    );

    // Free-running clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: every result strobe must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst && MUL_valid_out) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid_out: got valid_out=1 expected no result at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output($sformatf("op%0d_hi", e.id), MUL_result_hi, e.hi);
                check_output($sformatf("op%0d_lo", e.id), MUL_result_lo, e.lo);
                check_output($sformatf("op%0d_latency", e.id), 64'(cyc - e.acc_cyc + 1), 64'(e.lat));
            end
        end
    end

    // Drive one request for a single edge, then scramble the inputs so any
    // failure to latch at accept shows up in the result
    task automatic apply_stimulus(input logic mulw, input logic [1:0] sgn,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic push, input logic [63:0] eh,
                                  input logic [63:0] el, input int lat, input int id);
        exp_t e;
        check_output($sformatf("op%0d_ready_at_issue", id), 64'(MUL_ready), 64'd1);
        MUL_valid_in     = 1'b1;
        MUL_mulw         = mulw;
        MUL_signed       = sgn;
        MUL_multiplicand = a;
        MUL_multiplier   = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.hi      = eh;
            e.lo      = el;
            e.acc_cyc = cyc;
            e.lat     = lat;
            e.id      = id;
            sb.push_back(e);
            last_hi   = eh;
            last_lo   = el;
        end
        MUL_valid_in     = 1'b0;
        MUL_mulw         = ~mulw;
        MUL_signed       = ~sgn;
        MUL_multiplicand = {$urandom, $urandom};
        MUL_multiplier   = {$urandom, $urandom};
    endtask

    // Wait for the scoreboard to drain, counting cycles where the DUT looked
    // idle while a result was still owed
    task automatic wait_done(input int budget, output int rdy);
        rdy = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) break;
            if (MUL_ready && !MUL_valid_out) rdy++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (MUL_valid_out) break;
        end
        if (i == budget) begin
            checks++;
            errors++;
            $display("[TB] FAIL valid_timeout: got valid_out=0 expected 1 within %0d cycles", budget);
        end
    endtask

    // Directed sequence
    initial begin
        checks           = 0;
        errors           = 0;
        last_hi          = '0;
        last_lo          = '0;
        rst              = 1'b0;
        MUL_valid_in     = 1'b0;
        MUL_flush        = 1'b0;
        MUL_mulw         = 1'b0;
        MUL_signed       = 2'b00;
        MUL_multiplicand = '0;
        MUL_multiplier   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ready", 64'(MUL_ready), 64'd1);
        check_output("reset_valid", 64'(MUL_valid_out), 64'd0);
        check_output("reset_hi", MUL_result_hi, 64'd0);
        check_output("reset_lo", MUL_result_lo, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Unsigned all-ones x 2
        apply_stimulus(1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1,
                       64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1);
        wait_done(60, ready_hi);
        check_output("op1_ready_low_while_busy", 64'(ready_hi), 64'd0);

        // Signed -3 x 5
        apply_stimulus(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1, 34, 2);
        wait_done(60, ready_hi);

        // Most negative squared
        apply_stimulus(1'b0, 2'b11, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
                       64'h4000_0000_0000_0000, 64'h0, 34, 3);
        wait_done(60, ready_hi);

        // Signed -1 x unsigned (2^64-1)
        apply_stimulus(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                       64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 34, 4);
        wait_done(60, ready_hi);

        // Word mode signed, upper operand bits must be ignored
        apply_stimulus(1'b1, 2'b11, 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 1'b1,
                       64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 18, 5);
        wait_done(40, ready_hi);
        check_output("op5_ready_low_while_busy", 64'(ready_hi), 64'd0);

        // Word mode unsigned: 0xFFFFFFFF x 2 = 0x1_FFFFFFFE, low half sign-extended
        apply_stimulus(1'b1, 2'b00, 64'hABCD_0000_FFFF_FFFF, 64'h5555_0000_0000_0002, 1'b1,
                       64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 18, 6);
        wait_done(40, ready_hi);

        // Zero operand keeps full latency
        apply_stimulus(1'b0, 2'b11, 64'h0, 64'h1234_5678_9ABC_DEF0, 1'b1,
                       64'h0, 64'h0, 34, 7);
        wait_done(60, ready_hi);

        // Back-to-back: accept the next op in the valid_out cycle
        apply_stimulus(1'b0, 2'b00, 64'd3, 64'd4, 1'b1, 64'h0, 64'd12, 34, 8);
        wait_valid(60);
        apply_stimulus(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                       64'h0, 64'h1, 34, 9);
        wait_done(60, ready_hi);

        // Flush in IDLE blocks a coincident request
        MUL_valid_in = 1'b1;
        MUL_flush    = 1'b1;
        @(posedge clk);
        #1;
        check_output("idle_flush_blocks_accept", 64'(MUL_ready), 64'd1);
        MUL_valid_in = 1'b0;
        MUL_flush    = 1'b0;

        // Flush ten cycles into CALC, results held
        apply_stimulus(1'b0, 2'b00, 64'd1000, 64'd1000, 1'b0, 64'h0, 64'h0, 34, 10);
        repeat (10) @(posedge clk);
        @(negedge clk);
        MUL_flush = 1'b1;
        @(posedge clk);
        #1;
        MUL_flush = 1'b0;
        check_output("flush_ready", 64'(MUL_ready), 64'd1);
        check_output("flush_hold_hi", MUL_result_hi, last_hi);
        check_output("flush_hold_lo", MUL_result_lo, last_lo);
        apply_stimulus(1'b0, 2'b00, 64'd7, 64'd6, 1'b1, 64'h0, 64'd42, 34, 11);
        wait_done(60, ready_hi);

        // Reset mid-CALC, then accept on the first edge after release
        apply_stimulus(1'b0, 2'b00, 64'd99, 64'd99, 1'b0, 64'h0, 64'h0, 34, 12);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("midreset_ready", 64'(MUL_ready), 64'd1);
        check_output("midreset_valid", 64'(MUL_valid_out), 64'd0);
        check_output("midreset_hi", MUL_result_hi, 64'd0);
        check_output("midreset_lo", MUL_result_lo, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apply_stimulus(1'b0, 2'b00, 64'd7, 64'd6, 1'b1, 64'h0, 64'd42, 34, 13);
        wait_done(60, ready_hi);

        repeat (40) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
